// File: rtl/seg7_scan_n_if.sv
// Load-side bus of the seven-segment scanner: new digit data plus its
// load strobe and the acknowledge that fires once the data is on display.
interface seg7_scan_n_if #(
  parameter int DIGITS = 8
);
  logic [4*DIGITS-1:0] x;
  logic [DIGITS-1:0]   dp_in;
  logic [DIGITS-1:0]   blink_en;
  logic                load;
  logic                load_ack;

  modport master (
    output x, dp_in, blink_en, load,
    input  load_ack
  );

  modport slave (
    input  x, dp_in, blink_en, load,
    output load_ack
  );
endinterface

// File: rtl/seg7_scan_n.sv
// Multiplexed common-anode seven-segment driver. New values wait in a
// shadow register and are only applied at a frame boundary, so a scan
// never shows half-old, half-new digits. Adds an anti-ghosting blank gap,
// leading-zero suppression and per-digit blinking.
module seg7_scan_n #(
  parameter int DIGITS       = 8,
  parameter int DWELL        = 250000,
  parameter int GAP          = 1000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic              clk,
  input  logic              rst,
  seg7_scan_n_if.slave      bus,
  input  logic              lz_en_i,
  output logic              frame_tick_o,
  output logic [6:0]        a_to_g_o,
  output logic [DIGITS-1:0] an_o,
  output logic              dp_o
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_C   = CNT_W'(GAP);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [FRM_W-1:0]    frameCnt_q;
  logic                phase_q;
  logic                frameTick_q;
  logic                boundary;

  logic [4*DIGITS-1:0] shadowX_q, activeX_q;
  logic [DIGITS-1:0]   shadowDp_q, activeDp_q;
  logic [DIGITS-1:0]   shadowBlink_q, activeBlink_q;
  logic                pending_q;
  logic                loadAck_q;

  logic [DIGITS:0]     zeroChain;
  logic [3:0]          curNib;
  logic                curDp, curBlink, curZero, blank;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;

  assign boundary     = (idx_q == IDX_MAX) && (cnt_q == CNT_MAX);
  assign bus.load_ack = loadAck_q;
  assign frame_tick_o = frameTick_q;
  assign an_o         = an_q;
  assign a_to_g_o     = seg_q;
  assign dp_o         = dp_q;

  // Next dwell position: count within the digit, then step to the next digit.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    end
  end

  // Dwell counter and digit index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
    end
  end

  // Frame tick and blink phase, which flips every BLINK_FRAMES frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frameCnt_q  <= '0;
      phase_q     <= 1'b0;
      frameTick_q <= 1'b0;
    end else begin
      frameTick_q <= boundary;
      if (boundary) begin
        if (frameCnt_q == FRM_MAX) begin
          frameCnt_q <= '0;
          phase_q    <= ~phase_q;
        end else begin
          frameCnt_q <= frameCnt_q + 1'b1;
        end
      end
    end
  end

  // Shadow capture and boundary transfer; a load in the boundary cycle
  // itself becomes the next pending value while the old shadow goes live.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadowX_q     <= '0;
      shadowDp_q    <= '0;
      shadowBlink_q <= '0;
      activeX_q     <= '0;
      activeDp_q    <= '0;
      activeBlink_q <= '0;
      pending_q     <= 1'b0;
      loadAck_q     <= 1'b0;
    end else begin
      loadAck_q <= 1'b0;
      if (boundary && pending_q) begin
        activeX_q     <= shadowX_q;
        activeDp_q    <= shadowDp_q;
        activeBlink_q <= shadowBlink_q;
        loadAck_q     <= 1'b1;
      end
      if (bus.load) begin
        shadowX_q     <= bus.x;
        shadowDp_q    <= bus.dp_in;
        shadowBlink_q <= bus.blink_en;
        pending_q     <= 1'b1;
      end else if (boundary) begin
        pending_q <= 1'b0;
      end
    end
  end

  // Select the current digit's data and decide whether it is blanked.
  always_comb begin
    zeroChain         = '0;
    zeroChain[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zeroChain[i] = zeroChain[i+1] && (activeX_q[4*i +: 4] == 4'd0);
    end
    curNib   = 4'd0;
    curDp    = 1'b0;
    curBlink = 1'b0;
    curZero  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        curNib   = activeX_q[4*i +: 4];
        curDp    = activeDp_q[i];
        curBlink = activeBlink_q[i];
        curZero  = zeroChain[i];
      end
    end
    blank = (cnt_q < GAP_C)
         || (lz_en_i && (idx_q != '0) && curZero)
         || (phase_q && curBlink);
  end

  // Pin values for the next cycle: hex decode and one-hot-low anode.
  always_comb begin
    case (curNib)
      4'h0:    seg_d = 7'b0000001;
      4'h1:    seg_d = 7'b1001111;
      4'h2:    seg_d = 7'b0010010;
      4'h3:    seg_d = 7'b0000110;
      4'h4:    seg_d = 7'b1001100;
      4'h5:    seg_d = 7'b0100100;
      4'h6:    seg_d = 7'b0100000;
      4'h7:    seg_d = 7'b0001111;
      4'h8:    seg_d = 7'b0000000;
      4'h9:    seg_d = 7'b0000100;
      4'hA:    seg_d = 7'b0001000;
      4'hB:    seg_d = 7'b1100000;
      4'hC:    seg_d = 7'b0110001;
      4'hD:    seg_d = 7'b1000010;
      4'hE:    seg_d = 7'b0110000;
      default: seg_d = 7'b0111000;
    endcase
    an_d = ~(DIGITS'(1) << idx_q);
    dp_d = ~curDp;
    if (blank) begin
      seg_d = 7'b1111111;
      an_d  = '1;
      dp_d  = 1'b1;
    end
  end

  // Registered display outputs, all dark in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= '1;
      seg_q <= 7'b1111111;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_n.sv
// Self-checking bench for seg7_scan_n with a small 4-digit scan. Loads are
// pushed into a scoreboard together with the edge at which their
// acknowledge is due; the display expected each cycle follows the values
// popped from it.
module tb_seg7_scan_n;

  localparam int DIGITS       = 4;
  localparam int DWELL        = 8;
  localparam int GAP          = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = DIGITS * DWELL;

  typedef struct {
    logic [15:0] x;
    logic [3:0]  dp;
    logic [3:0]  blink;
    int          ackEdge;
  } load_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       lzEn;
  logic       frameTick;
  logic [6:0] aToG;
  logic [3:0] an;
  logic       dp;

  load_t       sbQ[$];
  logic [15:0] actX;
  logic [3:0]  actDp;
  logic [3:0]  actBlink;
  int          edgeCnt;
  int          compared;
  int          mismatched;
  int          ackSeen;

  seg7_scan_n_if #(.DIGITS(DIGITS)) bus ();

  seg7_scan_n #(
    .DIGITS(DIGITS), .DWELL(DWELL), .GAP(GAP), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .lz_en_i(lzEn),
    .frame_tick_o(frameTick), .a_to_g_o(aToG), .an_o(an), .dp_o(dp)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  function automatic logic [6:0] segOf(input logic [3:0] h);
    logic [6:0] table_v [16];
    table_v = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    return table_v[h];
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s at edge %0d: observed %h, expected %h",
             tag, edgeCnt, observed, expected);
    end
  endtask

  // One clock: sample just after the edge and compare against what the
  // display should show for the state held during the previous cycle.
  task automatic stepAndCheck();
    int s, pos, d, off, phase;
    logic [3:0] nib;
    logic blankV, expAck;
    logic [3:0] expAn;
    logic [6:0] expSeg;
    logic expDp;
    @(posedge clk);
    #1;
    edgeCnt++;
    s     = edgeCnt - 1;
    pos   = s % FRAME;
    d     = pos / DWELL;
    off   = pos % DWELL;
    phase = (s / (FRAME * BLINK_FRAMES)) % 2;
    nib   = 4'((actX >> (4 * d)) & 16'hF);
    blankV = (off < GAP)
          || (lzEn && d != 0 && ((actX >> (4 * d)) == 16'd0))
          || (phase == 1 && actBlink[d]);
    expAn  = blankV ? 4'hF : ~(4'b0001 << d);
    expSeg = blankV ? 7'h7F : segOf(nib);
    expDp  = blankV ? 1'b1 : ~actDp[d];
    expAck = (sbQ.size() > 0) && (sbQ[0].ackEdge == edgeCnt);
    checkOutput("an", {12'd0, an}, {12'd0, expAn});
    checkOutput("a_to_g", {9'd0, aToG}, {9'd0, expSeg});
    checkOutput("dp", {15'd0, dp}, {15'd0, expDp});
    checkOutput("frame_tick", {15'd0, frameTick}, {15'd0, 1'(edgeCnt % FRAME == 0)});
    checkOutput("load_ack", {15'd0, bus.load_ack}, {15'd0, expAck});
    if (bus.load_ack) ackSeen++;
    if (expAck) begin
      actX     = sbQ[0].x;
      actDp    = sbQ[0].dp;
      actBlink = sbQ[0].blink;
      void'(sbQ.pop_front());
    end
  endtask

  task automatic runUntil(input int target);
    while (edgeCnt < target) stepAndCheck();
  endtask

  // One-cycle load; the ack is due at the first frame start after capture,
  // and a second load aimed at the same frame replaces the first.
  task automatic applyStimulus(input logic [15:0] xv, input logic [3:0] dpv,
                               input logic [3:0] blv);
    load_t item;
    int capEdge;
    bus.x        = xv;
    bus.dp_in    = dpv;
    bus.blink_en = blv;
    bus.load     = 1'b1;
    capEdge      = edgeCnt + 1;
    item.x       = xv;
    item.dp      = dpv;
    item.blink   = blv;
    item.ackEdge = (capEdge / FRAME + 1) * FRAME;
    if (sbQ.size() > 0 && sbQ[sbQ.size()-1].ackEdge == item.ackEdge)
      sbQ[sbQ.size()-1] = item;
    else
      sbQ.push_back(item);
    stepAndCheck();
    bus.load = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_an"}, {12'd0, an}, 16'h000F);
    checkOutput({tag, "_a_to_g"}, {9'd0, aToG}, 16'h007F);
    checkOutput({tag, "_dp"}, {15'd0, dp}, 16'h0001);
    checkOutput({tag, "_load_ack"}, {15'd0, bus.load_ack}, 16'h0000);
    checkOutput({tag, "_frame_tick"}, {15'd0, frameTick}, 16'h0000);
  endtask

  task automatic releaseReset();
    rst      = 1'b0;
    edgeCnt  = 0;
    actX     = '0;
    actDp    = '0;
    actBlink = '0;
    sbQ.delete();
  endtask

  // Directed sequence: scan, load, overwrite, boundary load, LZ, blink/dp,
  // then reset while a load is pending.
  initial begin
    compared     = 0;
    mismatched   = 0;
    ackSeen      = 0;
    edgeCnt      = 0;
    rst          = 1'b1;
    lzEn         = 1'b0;
    bus.x        = '0;
    bus.dp_in    = '0;
    bus.blink_en = '0;
    bus.load     = 1'b0;
    actX         = '0;
    actDp        = '0;
    actBlink     = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    releaseReset();
    $display("[TB] scan with all-zero data");
    runUntil(40);

    $display("[TB] mid-frame load of 12AF");
    applyStimulus(16'h12AF, 4'b0000, 4'b0000);
    runUntil(100);

    $display("[TB] overwrite within a frame, then load on the boundary");
    applyStimulus(16'h1111, 4'b0000, 4'b0000);
    runUntil(110);
    applyStimulus(16'h2222, 4'b0000, 4'b0000);
    runUntil(127);
    applyStimulus(16'h3333, 4'b0000, 4'b0000);
    runUntil(170);

    $display("[TB] leading-zero suppression");
    lzEn = 1'b1;
    applyStimulus(16'h0050, 4'b0000, 4'b0000);
    runUntil(230);
    applyStimulus(16'h0000, 4'b0000, 4'b0000);
    runUntil(290);

    $display("[TB] blink on digit 0, decimal point on digit 2");
    lzEn = 1'b0;
    applyStimulus(16'h8765, 4'b0100, 4'b0001);
    runUntil(470);

    $display("[TB] reset while a load is pending");
    applyStimulus(16'h9999, 4'b1111, 4'b0000);
    runUntil(475);
    rst = 1'b1;
    #1;
    checkResetOutputs("midreset");
    repeat (2) @(posedge clk);
    #1;
    releaseReset();
    runUntil(80);

    checkOutput("ack_total", 16'(ackSeen), 16'd6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
